// File: rtl/axi_local_mem_slave.sv
// axi_local_mem_slave: single-beat AXI responder in front of a word-addressed RAM.
// AW and W are held independently. A complete write pair executes from IDLE.
// Reads return data one edge after the AR capture.
// Optional feature: `define AXI_SLAVE_EXCLUSIVE_EN enables the exclusive-access
// reservation monitor. Without it, lock bits only select the EXOKAY response,
// which is safe for single-master systems only.
module axi_local_mem_slave #(
    parameter int DEPTH = 4096,
    parameter int ID_W  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_axi_awvalid,
    output logic            s_axi_awready,
    input  logic [31:0]     s_axi_awaddr,
    input  logic [ID_W-1:0] s_axi_awid,
    input  logic            s_axi_awlock,
    input  logic            s_axi_wvalid,
    output logic            s_axi_wready,
    input  logic [31:0]     s_axi_wdata,
    input  logic [3:0]      s_axi_wstrb,
    output logic            s_axi_bvalid,
    input  logic            s_axi_bready,
    output logic [1:0]      s_axi_bresp,
    output logic [ID_W-1:0] s_axi_bid,
    input  logic            s_axi_arvalid,
    output logic            s_axi_arready,
    input  logic [31:0]     s_axi_araddr,
    input  logic [ID_W-1:0] s_axi_arid,
    input  logic            s_axi_arlock,
    output logic            s_axi_rvalid,
    input  logic            s_axi_rready,
    output logic [31:0]     s_axi_rdata,
    output logic [1:0]      s_axi_rresp,
    output logic [ID_W-1:0] s_axi_rid,
    output logic            s_axi_rlast
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE_RESP, READ_RESP} state_t;

    state_t          state;
    logic [31:0]     mem [DEPTH];

    logic            aw_held, w_held;
    logic [29:0]     aw_idx_q;
    logic            aw_lock_q;
    logic [ID_W-1:0] aw_id_q;
    logic [31:0]     w_data_q;
    logic [3:0]      w_strb_q;
    logic [29:0]     ar_idx_q;
    logic [ID_W-1:0] ar_id_q;

    logic            aw_hs, w_hs, ar_hs, wr_go;
    logic            wr_in_range, wr_commit, rd_in_range;
    logic [1:0]      wr_bresp, rd_rresp;

    // Byte-offset bits carry no information for a word-wide RAM.
    logic            unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

`ifdef AXI_SLAVE_EXCLUSIVE_EN
    logic            res_valid;
    logic [29:0]     res_addr;
    logic            res_match, res_clr, ar_in_range;
`else
    logic            ar_lock_q;
`endif

    // Readies drop during reset; a full write pair blocks new reads.
    assign s_axi_awready = ~rst & ~aw_held;
    assign s_axi_wready  = ~rst & ~w_held;
    assign s_axi_arready = ~rst & (state == IDLE) & ~(aw_held & w_held);
    assign s_axi_rlast   = 1'b1;

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid & s_axi_wready;
    assign ar_hs = s_axi_arvalid & s_axi_arready;
    assign wr_go = (state == IDLE) & aw_held & w_held;

    // Decide whether the held write commits and what it answers.
    always_comb begin
        wr_in_range = ({2'b00, aw_idx_q} < 32'(DEPTH));
        wr_commit   = 1'b0;
        wr_bresp    = 2'b10;
`ifdef AXI_SLAVE_EXCLUSIVE_EN
        res_match   = res_valid & (res_addr == aw_idx_q);
        res_clr     = 1'b0;
        if (wr_in_range) begin
            // Exclusive writes need a live matching reservation; any
            // exclusive attempt or a normal write to the address kills it.
            wr_commit = ~aw_lock_q | res_match;
            wr_bresp  = (aw_lock_q & res_match) ? 2'b01 : 2'b00;
            res_clr   = aw_lock_q | res_match;
        end
`else
        if (wr_in_range) begin
            wr_commit = 1'b1;
            wr_bresp  = aw_lock_q ? 2'b01 : 2'b00;
        end
`endif
    end

    // Read response code from the captured read index.
    always_comb begin
        rd_in_range = ({2'b00, ar_idx_q} < 32'(DEPTH));
`ifdef AXI_SLAVE_EXCLUSIVE_EN
        rd_rresp    = rd_in_range ? 2'b00 : 2'b10;
`else
        rd_rresp    = !rd_in_range ? 2'b10 : (ar_lock_q ? 2'b01 : 2'b00);
`endif
    end

    // Request capture, transaction FSM and registered response channels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_idx_q     <= '0;
            aw_lock_q    <= 1'b0;
            aw_id_q      <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            ar_idx_q     <= '0;
            ar_id_q      <= '0;
`ifndef AXI_SLAVE_EXCLUSIVE_EN
            ar_lock_q    <= 1'b0;
`endif
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= 2'b00;
            s_axi_bid    <= '0;
            s_axi_rvalid <= 1'b0;
            s_axi_rresp  <= 2'b00;
            s_axi_rid    <= '0;
            s_axi_rdata  <= '0;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_idx_q  <= s_axi_awaddr[31:2];
                aw_lock_q <= s_axi_awlock;
                aw_id_q   <= s_axi_awid;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= s_axi_wdata;
                w_strb_q <= s_axi_wstrb;
            end
            case (state)
                IDLE: begin
                    if (wr_go) begin
                        aw_held      <= 1'b0;
                        w_held       <= 1'b0;
                        s_axi_bvalid <= 1'b1;
                        s_axi_bresp  <= wr_bresp;
                        s_axi_bid    <= aw_id_q;
                        state        <= WRITE_RESP;
                    end else if (ar_hs) begin
                        ar_idx_q  <= s_axi_araddr[31:2];
                        ar_id_q   <= s_axi_arid;
`ifndef AXI_SLAVE_EXCLUSIVE_EN
                        ar_lock_q <= s_axi_arlock;
`endif
                        state     <= READ_RESP;
                    end
                end
                WRITE_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                READ_RESP: begin
                    // First cycle here performs the RAM read; then hold until taken.
                    if (!s_axi_rvalid) begin
                        s_axi_rvalid <= 1'b1;
                        s_axi_rdata  <= rd_in_range ? mem[ar_idx_q[AW-1:0]] : 32'h0;
                        s_axi_rresp  <= rd_rresp;
                        s_axi_rid    <= ar_id_q;
                    end else if (s_axi_rready) begin
                        s_axi_rvalid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM write port with byte strobes; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_go && wr_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb_q[b]) mem[aw_idx_q[AW-1:0]][8*b +: 8] <= w_data_q[8*b +: 8];
            end
        end
    end

`ifdef AXI_SLAVE_EXCLUSIVE_EN
    assign ar_in_range = ({2'b00, s_axi_araddr[31:2]} < 32'(DEPTH));

    // Reservation monitor: set by in-range exclusive reads, cleared by writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_addr  <= '0;
        end else if (wr_go && res_clr) begin
            res_valid <= 1'b0;
        end else if (ar_hs && s_axi_arlock && ar_in_range) begin
            res_valid <= 1'b1;
            res_addr  <= s_axi_araddr[31:2];
        end
    end
`endif

endmodule

// File: tb/tb_axi_local_mem_slave.sv
// Directed bench for axi_local_mem_slave with a transaction-level memory model.
module tb_axi_local_mem_slave;
    localparam int DEPTH = 4096;
    localparam int ID_W  = 4;
`ifdef AXI_SLAVE_EXCLUSIVE_EN
    localparam bit EXCL = 1'b1;
`else
    localparam bit EXCL = 1'b0;
`endif

    logic            clk, rst;
    logic            s_axi_awvalid, s_axi_awready, s_axi_awlock;
    logic [31:0]     s_axi_awaddr;
    logic [ID_W-1:0] s_axi_awid;
    logic            s_axi_wvalid, s_axi_wready;
    logic [31:0]     s_axi_wdata;
    logic [3:0]      s_axi_wstrb;
    logic            s_axi_bvalid, s_axi_bready;
    logic [1:0]      s_axi_bresp;
    logic [ID_W-1:0] s_axi_bid;
    logic            s_axi_arvalid, s_axi_arready, s_axi_arlock;
    logic [31:0]     s_axi_araddr;
    logic [ID_W-1:0] s_axi_arid;
    logic            s_axi_rvalid, s_axi_rready, s_axi_rlast;
    logic [31:0]     s_axi_rdata;
    logic [1:0]      s_axi_rresp;
    logic [ID_W-1:0] s_axi_rid;

    axi_local_mem_slave #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
        .s_axi_awid(s_axi_awid), .s_axi_awlock(s_axi_awlock),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
        .s_axi_wstrb(s_axi_wstrb),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
        .s_axi_bid(s_axi_bid),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
        .s_axi_arid(s_axi_arid), .s_axi_arlock(s_axi_arlock),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
        .s_axi_rresp(s_axi_rresp), .s_axi_rid(s_axi_rid), .s_axi_rlast(s_axi_rlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mdl_mem [int unsigned];
    bit          res_v = 1'b0;
    int unsigned res_a = 0;
    logic [31:0] exp_b [$];   // {id, resp}
    logic [31:0] exp_r [$];   // {id, resp}
    logic [31:0] exp_d [$];   // read data

    task automatic mdl_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic lock, input logic [ID_W-1:0] id);
        int unsigned idx = addr >> 2;
        logic [31:0] w;
        bit ok;
        logic [1:0] resp;
        if (idx >= DEPTH) begin
            resp = 2'b10;
        end else begin
            ok   = !lock || !EXCL || (res_v && res_a == idx);
            resp = (lock && ok) ? 2'b01 : 2'b00;
            if (EXCL && (lock || res_a == idx)) res_v = 1'b0;
            if (ok) begin
                w = mdl_mem.exists(idx) ? mdl_mem[idx] : 32'h0;
                for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
                mdl_mem[idx] = w;
            end
        end
        exp_b.push_back({26'(id), 4'h0, resp});
    endtask

    task automatic mdl_read(input logic [31:0] addr, input logic lock, input logic [ID_W-1:0] id);
        int unsigned idx = addr >> 2;
        if (idx >= DEPTH) begin
            exp_d.push_back(32'h0);
            exp_r.push_back({26'(id), 4'h0, 2'b10});
        end else begin
            exp_d.push_back(mdl_mem.exists(idx) ? mdl_mem[idx] : 32'h0);
            exp_r.push_back({26'(id), 4'h0, (lock && !EXCL) ? 2'b01 : 2'b00});
            if (EXCL && lock) begin
                res_v = 1'b1;
                res_a = idx;
            end
        end
    endtask

    // ---------------- compare process ----------------
    bit          pb_stall = 0, pr_stall = 0;
    logic [31:0] pb_val, pr_val, pr_dat;
    always @(negedge clk) begin
        if (rst) begin
            pb_stall = 0;
            pr_stall = 0;
        end else begin
            if (pb_stall) begin
                chk("b_hold_valid", 32'(s_axi_bvalid), 32'd1);
                chk("b_hold_fields", {26'(s_axi_bid), 4'h0, s_axi_bresp}, pb_val);
            end
            if (pr_stall) begin
                chk("r_hold_valid", 32'(s_axi_rvalid), 32'd1);
                chk("r_hold_fields", {26'(s_axi_rid), 4'h0, s_axi_rresp}, pr_val);
                chk("r_hold_data", s_axi_rdata, pr_dat);
            end
            if (s_axi_bvalid && s_axi_bready) begin
                if (exp_b.size() == 0) chk("b_unexpected", 32'(s_axi_bvalid), 32'd0);
                else chk("b_resp_id", {26'(s_axi_bid), 4'h0, s_axi_bresp}, exp_b.pop_front());
            end
            if (s_axi_rvalid && s_axi_rready) begin
                if (exp_r.size() == 0) chk("r_unexpected", 32'(s_axi_rvalid), 32'd0);
                else begin
                    chk("r_resp_id", {26'(s_axi_rid), 4'h0, s_axi_rresp}, exp_r.pop_front());
                    chk("r_data", s_axi_rdata, exp_d.pop_front());
                end
                chk("r_last", 32'(s_axi_rlast), 32'd1);
            end
            pb_stall = s_axi_bvalid && !s_axi_bready;
            pb_val   = {26'(s_axi_bid), 4'h0, s_axi_bresp};
            pr_stall = s_axi_rvalid && !s_axi_rready;
            pr_val   = {26'(s_axi_rid), 4'h0, s_axi_rresp};
            pr_dat   = s_axi_rdata;
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic rdy(input int ch);
        case (ch)
            0:       return s_axi_awready & s_axi_wready;
            1:       return s_axi_wready;
            2:       return s_axi_awready;
            default: return s_axi_arready;
        endcase
    endfunction

    // Returns #1 after the edge on which the handshake happened.
    task automatic wait_rdy(input int ch);
        int n = 0;
        @(negedge clk);
        while (!rdy(ch) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("handshake_ready", 32'(rdy(ch)), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Drives AW/W (W optionally leading by w_lead cycles) and checks that
    // bvalid appears exactly one edge after the later capture.
    task automatic wr_issue(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic lock, input logic [ID_W-1:0] id, input int w_lead);
        @(posedge clk);
        #1;
        s_axi_wvalid = 1'b1; s_axi_wdata = data; s_axi_wstrb = strb;
        s_axi_awaddr = addr; s_axi_awlock = lock; s_axi_awid = id;
        if (w_lead > 0) begin
            wait_rdy(1);
            s_axi_wvalid = 1'b0;
            @(negedge clk);
            chk("b_waits_for_aw", 32'(s_axi_bvalid), 32'd0);
            repeat (w_lead - 1) @(posedge clk);
            #1;
            s_axi_awvalid = 1'b1;
            wait_rdy(2);
        end else begin
            s_axi_awvalid = 1'b1;
            wait_rdy(0);
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        mdl_write(addr, data, strb, lock, id);
        @(negedge clk);
        chk("b_lat_capture_edge", 32'(s_axi_bvalid), 32'd0);
        @(negedge clk);
        chk("b_lat_next_edge", 32'(s_axi_bvalid), 32'd1);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic lock, input logic [ID_W-1:0] id, input int w_lead,
                             output logic [1:0] resp);
        int n = 0;
        wr_issue(addr, data, strb, lock, id, w_lead);
        while (!(s_axi_bvalid && s_axi_bready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b_handshake", 32'(s_axi_bvalid && s_axi_bready), 32'd1);
        resp = s_axi_bresp;
        @(posedge clk);
        #1;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic lock, input logic [ID_W-1:0] id,
                            output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        @(posedge clk);
        #1;
        s_axi_arvalid = 1'b1; s_axi_araddr = addr; s_axi_arlock = lock; s_axi_arid = id;
        wait_rdy(3);
        s_axi_arvalid = 1'b0;
        mdl_read(addr, lock, id);
        @(negedge clk);
        chk("r_lat_capture_edge", 32'(s_axi_rvalid), 32'd0);
        @(negedge clk);
        chk("r_lat_next_edge", 32'(s_axi_rvalid), 32'd1);
        while (!(s_axi_rvalid && s_axi_rready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("r_handshake", 32'(s_axi_rvalid && s_axi_rready), 32'd1);
        data = s_axi_rdata;
        resp = s_axi_rresp;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    logic [31:0] d;
    logic [1:0]  r;
    localparam logic [31:0] OOR = 32'(DEPTH * 4);

    initial begin
        rst = 1'b1;
        s_axi_awvalid = 0; s_axi_awaddr = 0; s_axi_awid = 0; s_axi_awlock = 0;
        s_axi_wvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0;
        s_axi_arvalid = 0; s_axi_araddr = 0; s_axi_arid = 0; s_axi_arlock = 0;
        s_axi_bready = 1; s_axi_rready = 1;
        repeat (2) @(negedge clk);
        chk("rst_readies", {29'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h0);
        chk("rst_valids", {30'h0, s_axi_bvalid, s_axi_rvalid}, 32'h0);
        chk("rst_resp_ids", {16'h0, s_axi_bresp, s_axi_rresp, 4'(s_axi_bid), 4'(s_axi_rid)}, 32'h0);
        chk("rst_rdata", s_axi_rdata, 32'h0);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_readies", {29'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h7);

        // Full-word write and read-back.
        axi_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 4'h3, 0, r);
        chk("wr10_bresp", 32'(r), 32'h0);
        axi_read(32'h10, 0, 4'h5, d, r);
        chk("rd10_data", d, 32'hDEADBEEF);
        chk("rd10_rresp", 32'(r), 32'h0);

        // W leads AW by 3 cycles; single byte lane 1.
        axi_write(32'h10, 32'h0000AB00, 4'b0010, 0, 4'h7, 3, r);
        axi_read(32'h10, 0, 4'h1, d, r);
        chk("strobe_merge", d, 32'hDEADABEF);

        // Exclusive pair succeeds, a repeat exclusive write fails.
        axi_write(32'h20, 32'h11, 4'hF, 0, 4'h2, 0, r);
        axi_read(32'h20, 1, 4'h4, d, r);
        chk("ex_rd_rresp", 32'(r), EXCL ? 32'h0 : 32'h1);
        chk("ex_rd_data", d, 32'h11);
        axi_write(32'h20, 32'h5, 4'hF, 1, 4'h8, 0, r);
        chk("ex_wr1_bresp", 32'(r), 32'h1);
        axi_write(32'h20, 32'h6, 4'hF, 1, 4'h9, 0, r);
        chk("ex_wr2_bresp", 32'(r), EXCL ? 32'h0 : 32'h1);
        axi_read(32'h20, 0, 4'h0, d, r);
        chk("ex_wr2_ram", d, EXCL ? 32'h5 : 32'h6);

        // Intervening normal write to the same word kills the reservation.
        axi_read(32'h20, 1, 4'hA, d, r);
        axi_write(32'h20, 32'h9, 4'hF, 0, 4'hB, 0, r);
        axi_write(32'h20, 32'hA, 4'hF, 1, 4'hC, 0, r);
        chk("ex_killed_bresp", 32'(r), EXCL ? 32'h0 : 32'h1);
        axi_read(32'h20, 0, 4'hD, d, r);
        chk("ex_killed_ram", d, EXCL ? 32'h9 : 32'hA);
        // A normal write elsewhere leaves it alive.
        axi_read(32'h20, 1, 4'hE, d, r);
        axi_write(32'h24, 32'h1, 4'hF, 0, 4'hF, 0, r);
        axi_write(32'h20, 32'hB, 4'hF, 1, 4'h1, 0, r);
        chk("ex_other_addr_bresp", 32'(r), 32'h1);

        // Out-of-range accesses; the reservation survives the failed write.
        axi_read(OOR, 0, 4'h2, d, r);
        chk("oor_rresp", 32'(r), 32'h2);
        chk("oor_rdata", d, 32'h0);
        axi_read(32'h20, 1, 4'h3, d, r);
        axi_write(OOR, 32'hFFFF_FFFF, 4'hF, 0, 4'h4, 0, r);
        chk("oor_bresp", 32'(r), 32'h2);
        axi_write(32'h20, 32'hC, 4'hF, 1, 4'h5, 0, r);
        chk("oor_res_kept_bresp", 32'(r), 32'h1);

        // Zero-strobe write is an OKAY no-op.
        axi_write(32'h10, 32'h1234_5678, 4'h0, 0, 4'h6, 0, r);
        chk("nostrb_bresp", 32'(r), 32'h0);
        axi_read(32'h10, 0, 4'h7, d, r);
        chk("nostrb_ram", d, 32'hDEADABEF);

        // Stall the B channel, then reset in the middle of the response.
        s_axi_bready = 1'b0;
        wr_issue(32'h30, 32'h1234_5678, 4'hF, 0, 4'h6, 0);
        repeat (5) @(negedge clk);
        chk("b_stalled", 32'(s_axi_bvalid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        chk("mid_rst_readies", {29'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h0);
        exp_b.delete();
        exp_r.delete();
        exp_d.delete();
        res_v = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        s_axi_bready = 1'b1;
        @(negedge clk);
        chk("post_rst2_readies", {29'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h7);
        axi_read(32'h30, 0, 4'h8, d, r);
        chk("ram_kept_over_rst", d, 32'h1234_5678);

        repeat (3) @(negedge clk);
        chk("b_queue_drained", 32'(exp_b.size()), 32'd0);
        chk("r_queue_drained", 32'(exp_r.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
